// File: rtl/multiplier_adapter_pkg.sv
// Shared types and sizing helpers for the iterative signed multiplier.
package multiplier_adapter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2,
      DONE   = 2'd3
   } state_t;

   function automatic int calc_iters(input int w, input int d);
      return (w + d - 1) / d;
   endfunction

   // The counter must be able to hold N itself, not just N-1.
   function automatic int calc_cnt_w(input int w, input int d);
      return $clog2(calc_iters(w, d) + 1);
   endfunction

endpackage

// File: rtl/multiplier_adapter_mac.sv
// One iteration of the datapath: unsigned width x digit product, shifted by
// digit*k and added into the 2*width accumulator.
module mult_digit_mac #(
   parameter int width = 377,
   parameter int digit = 32,
   parameter int cnt_w = 4
) (
   input  logic [width-1:0]   i_ma,
   input  logic [digit-1:0]   i_md,
   input  logic [cnt_w-1:0]   i_k,
   input  logic [2*width-1:0] i_acc,
   output logic [2*width-1:0] o_acc
);

   logic [width+digit-1:0] w_prod;
   logic [2*width-1:0]     w_ext;
   logic [31:0]            w_shamt;

   assign w_prod  = {{digit{1'b0}}, i_ma} * {{width{1'b0}}, i_md};
   assign w_ext   = (2*width)'(w_prod);
   assign w_shamt = 32'(i_k) * 32'(digit);
   assign o_acc   = i_acc + (w_ext << w_shamt);

endmodule

// File: rtl/multiplier_adapter.sv
// Multi-cycle signed multiplier: sign-magnitude iterative datapath, full
// 2*width two's complement product, enable/done level handshake.
module multiplier_adapter
   import multiplier_adapter_pkg::*;
#(
   parameter int width = 377,
   parameter int digit = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [width-1:0]   a,
   input  logic [width-1:0]   b,
   output logic [2*width-1:0] ab,
   output logic               done,
   output state_t             o_dbg_state
);

   localparam int N     = calc_iters(width, digit);
   localparam int CNT_W = calc_cnt_w(width, digit);

   // Handshake: enable high in IDLE starts an operation (a/b sampled on that
   // edge only); done rises after N+2 edges and stays high with ab stable
   // while enable is held; enable low in DONE returns to IDLE, clearing done.
   state_t             r_state;
   logic [width-1:0]   r_ma;
   logic [width-1:0]   r_mb;
   logic               r_neg;
   logic [2*width-1:0] r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*width-1:0] r_ab;
   logic               r_done;

   logic [width-1:0]   w_abs_a;
   logic [width-1:0]   w_abs_b;
   logic               w_neg;
   logic [2*width-1:0] w_acc_next;

   assign w_abs_a = a[width-1] ? -a : a;
   assign w_abs_b = b[width-1] ? -b : b;
   assign w_neg   = (a[width-1] ^ b[width-1]) && (a != '0) && (b != '0);

   mult_digit_mac #(
      .width (width),
      .digit (digit),
      .cnt_w (CNT_W)
   ) u_mac (
      .i_ma  (r_ma),
      .i_md  (r_mb[digit-1:0]),
      .i_k   (r_cnt),
      .i_acc (r_acc),
      .o_acc (w_acc_next)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_ma    <= '0;
         r_mb    <= '0;
         r_neg   <= 1'b0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_ab    <= '0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (enable) begin
                  r_ma    <= w_abs_a;
                  r_mb    <= w_abs_b;
                  r_neg   <= w_neg;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               // The extra cycle at r_cnt == N keeps latency at N+2.
               if (r_cnt == CNT_W'(N)) begin
                  r_state <= FINISH;
               end else begin
                  r_acc <= w_acc_next;
                  r_mb  <= r_mb >> digit;
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            FINISH: begin
               r_ab    <= r_neg ? -r_acc : r_acc;
               r_done  <= 1'b1;
               r_state <= DONE;
            end
            DONE: begin
               if (!enable) begin
                  r_done  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ab          = r_ab;
   assign done        = r_done;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_multiplier_adapter.sv
// Self-checking bench: 377/32 instance for directed/handshake cases and an
// 8/3 instance for a randomized signed sweep.
module tb_multiplier_adapter;
   import multiplier_adapter_pkg::*;

   localparam int W     = 377;
   localparam int D     = 32;
   localparam int LAT_M = (W + D - 1) / D + 2;
   localparam int SW    = 8;
   localparam int SD    = 3;
   localparam int LAT_S = (SW + SD - 1) / SD + 2;

   logic           clk;
   logic           reset;
   logic           enable;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic [2*W-1:0] ab;
   logic           done;
   state_t         m_state;

   logic            s_enable;
   logic [SW-1:0]   sa;
   logic [SW-1:0]   sb;
   logic [2*SW-1:0] s_ab;
   logic            s_done;
   state_t          s_state;

   int n_cmp;
   int n_err;
   logic [2*W-1:0]  exp_q[$];
   logic [2*SW-1:0] s_exp_q[$];

   multiplier_adapter #(.width(W), .digit(D)) dut (
      .clk (clk), .reset (reset), .enable (enable), .a (a), .b (b),
      .ab (ab), .done (done), .o_dbg_state (m_state)
   );

   multiplier_adapter #(.width(SW), .digit(SD)) dut_s (
      .clk (clk), .reset (reset), .enable (s_enable), .a (sa), .b (sb),
      .ab (s_ab), .done (s_done), .o_dbg_state (s_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, expv);
      end
   endtask

   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
      logic signed [2*W-1:0] xs;
      logic signed [2*W-1:0] ys;
      xs = {{W{x[W-1]}}, x};
      ys = {{W{y[W-1]}}, y};
      return xs * ys;
   endfunction

   function automatic logic [2*SW-1:0] ref_mul_s(input logic [SW-1:0] x, input logic [SW-1:0] y);
      logic signed [2*SW-1:0] xs;
      logic signed [2*SW-1:0] ys;
      xs = {{SW{x[SW-1]}}, x};
      ys = {{SW{y[SW-1]}}, y};
      return xs * ys;
   endfunction

   // mode 0: hold enable after done; 1: also change a/b mid-RUN; 2: drop enable mid-RUN
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input int mode);
      int lat;
      bit got;
      logic [2*W-1:0] e;
      @(negedge clk);
      a = ta;
      b = tb;
      enable = 1'b1;
      exp_q.push_back(ref_mul(ta, tb));
      @(posedge clk);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 40) begin
         @(posedge clk);
         lat++;
         #1;
         if (done) got = 1'b1;
         if (lat == 3 && mode == 1) begin
            a = ~ta;
            b = ta ^ tb ^ {W{1'b1}};
         end
         if (lat == 2 && mode == 2) enable = 1'b0;
      end
      e = exp_q.pop_front();
      chk("latency", 754'(lat), 754'(LAT_M));
      chk("ab", ab, e);
      if (mode == 2) begin
         @(posedge clk);
         #1;
         chk("done_drop_early", 754'(done), 754'(0));
      end else begin
         repeat (3) begin
            @(posedge clk);
            #1;
            chk("done_hold", 754'(done), 754'(1));
            chk("ab_hold", ab, e);
         end
         @(negedge clk);
         enable = 1'b0;
         @(posedge clk);
         #1;
         chk("done_clear", 754'(done), 754'(0));
         chk("ab_kept", ab, e);
      end
   endtask

   task automatic s_op(input logic [SW-1:0] x, input logic [SW-1:0] y);
      int lat;
      bit got;
      logic [2*SW-1:0] e;
      @(negedge clk);
      sa = x;
      sb = y;
      s_enable = 1'b1;
      s_exp_q.push_back(ref_mul_s(x, y));
      @(posedge clk);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 20) begin
         @(posedge clk);
         lat++;
         #1;
         if (s_done) got = 1'b1;
      end
      e = s_exp_q.pop_front();
      chk("s_latency", 754'(lat), 754'(LAT_S));
      chk("s_ab", 754'(s_ab), 754'(e));
      @(negedge clk);
      s_enable = 1'b0;
      @(posedge clk);
      #1;
      chk("s_done_clear", 754'(s_done), 754'(0));
   endtask

   initial begin
      logic [W-1:0] wa;
      logic [W-1:0] wb;
      logic [W-1:0] min_v;
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      enable = 1'b0;
      a = '0;
      b = '0;
      s_enable = 1'b0;
      sa = '0;
      sb = '0;
      #1;
      chk("rst_ab", ab, '0);
      chk("rst_done", 754'(done), 754'(0));
      chk("rst_state", 754'(m_state), 754'(IDLE));
      chk("rst_s_done", 754'(s_done), 754'(0));
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      do_op(W'(3), -W'(5), 0);
      do_op(-W'(3), W'(5), 0);
      do_op(-W'(3), -W'(5), 0);
      do_op(W'(0), -W'(7), 0);

      wa = 377'h12818541fadc53f209e60e2a4648b497d54f933d91e537c643fda3a9f758d56c8d35343053b683f4837b6b35131177a;
      wb = 377'h13a6d3b1ea1e9b582d52f1f135bb62eeec445cc6512c7ff4a162209bead94acc8558f28e654f32ee03aee5934019393;
      wb = -wb;
      do_op(wa, wb, 0);

      min_v = {1'b1, {(W-1){1'b0}}};
      do_op(min_v, min_v, 0);
      do_op(min_v, {1'b0, {(W-1){1'b1}}}, 0);
      do_op({W{1'b1}}, {W{1'b1}}, 0);

      do_op(wb, wa ^ wb, 1);
      do_op(wa, -W'(12345), 2);

      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 12; j++) begin
            wa[j*32 +: 32] = $urandom;
            wb[j*32 +: 32] = $urandom;
         end
         wa[W-1 -: 25] = 25'($urandom);
         wb[W-1 -: 25] = 25'($urandom);
         do_op(wa, wb, 0);
      end

      // Reset between edges mid-RUN: outputs clear at once, no edge needed.
      @(negedge clk);
      a = wa;
      b = wb;
      enable = 1'b1;
      repeat (4) @(posedge clk);
      #3;
      reset = 1'b1;
      enable = 1'b0;
      #1;
      chk("midrst_ab", ab, '0);
      chk("midrst_done", 754'(done), 754'(0));
      chk("midrst_state", 754'(m_state), 754'(IDLE));
      @(negedge clk);
      reset = 1'b0;
      do_op(-W'(9), W'(11), 0);

      s_op(8'h80, 8'h80);
      s_op(8'h80, 8'h7f);
      s_op(8'hff, 8'hff);
      s_op(8'h00, 8'h85);
      s_op(8'h7f, 8'h7f);
      for (int i = 0; i < 400; i++) begin
         s_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
